// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and FIFO entry type for the fetch stage
package fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small in-order skid FIFO of {pc, instr} with a registered head
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [OCC_W-1:0] occ,
    output logic             head_valid,
    output fetch_entry_t     head
);

    // Entry 0 is always the head, so the head output is a plain register
    fetch_entry_t     r_mem [DEPTH];
    fetch_entry_t     w_up  [DEPTH];
    logic [OCC_W-1:0] r_occ;
    logic             r_valid;
    logic [OCC_W-1:0] w_wr_idx;
    logic [OCC_W-1:0] w_occ_next;

    // Each slot's successor, used when a pop shifts the queue towards the head
    always_comb begin
        for (int i = 0; i < DEPTH; i++) w_up[i] = r_mem[i];
        for (int i = 0; i < DEPTH - 1; i++) w_up[i] = r_mem[i + 1];
    end

    assign w_wr_idx   = r_occ - OCC_W'(pop);
    assign w_occ_next = r_occ + OCC_W'(push) - OCC_W'(pop);

    // Storage and occupancy; flush drops everything but leaves the head data untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ   <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_occ   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_occ   <= w_occ_next;
            r_valid <= (w_occ_next != '0);
            for (int i = 0; i < DEPTH; i++) begin
                if (push && w_wr_idx == OCC_W'(i))
                    r_mem[i] <= push_data;
                else if (pop && OCC_W'(i + 1) < r_occ)
                    r_mem[i] <= w_up[i];
            end
        end
    end

    // The issue logic upstream must never let a push land on a full queue
    always_ff @(posedge clk) begin
        if (!reset && !flush && push && !pop)
            assert (r_occ < OCC_W'(DEPTH));
    end

    assign occ        = r_occ;
    assign head_valid = r_valid;
    assign head       = r_mem[0];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, ROM latency absorption, redirect and range check
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          MEMORY_SIZE = 100,
    parameter int          BUF_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_enable,
    output logic [15:0] rom_address,
    input  logic [15:0] rom_instruction,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc,
    output logic        fetch_error
);

    localparam int                OCC_W      = $clog2(BUF_DEPTH + 1);
    localparam logic [ADDR_W:0]   MEM_SIZE_W = (ADDR_W + 1)'(MEMORY_SIZE);
    localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(MEMORY_SIZE - 1);
    localparam logic [OCC_W:0]    DEPTH_W    = (OCC_W + 1)'(BUF_DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight;
    logic              r_error;

    logic [ADDR_W-1:0] w_next_pc;
    logic              w_pop;
    logic              w_issue;
    logic              w_pc_oob;
    logic              w_range_fail;
    logic              w_redirect_ok;
    logic              w_head_valid;
    logic [OCC_W-1:0]  w_occ;
    logic [OCC_W:0]    w_level;
    fetch_entry_t      w_push_data;
    fetch_entry_t      w_head;

    // Slots committed after this cycle: queued + returning from ROM - leaving now
    assign w_pop         = w_head_valid & inst_ready;
    assign w_level       = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight} - {{OCC_W{1'b0}}, w_pop};
    assign w_pc_oob      = {1'b0, r_pc} >= MEM_SIZE_W;
    assign w_redirect_ok = {1'b0, redirect_pc} < MEM_SIZE_W;
    assign w_range_fail  = fetch_enable & ~redirect_valid & ~r_error & w_pc_oob;
    assign w_issue       = fetch_enable & ~r_error & ~redirect_valid & ~w_pc_oob
                         & (w_level < DEPTH_W);
    assign w_next_pc     = (r_pc == LAST_PC) ? '0 : r_pc + ADDR_W'(1);
    assign w_push_data   = '{pc: r_inflight_pc, instr: rom_instruction};

    // PC, in-flight tracking and the sticky range error; redirect outranks issue
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_error       <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
            if (w_redirect_ok) r_error <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= w_next_pc;
            end
            if (w_range_fail) r_error <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .occ       (w_occ),
        .head_valid(w_head_valid),
        .head      (w_head)
    );

    assign rom_address = r_pc;
    assign inst_valid  = w_head_valid;
    assign inst_data   = w_head.instr;
    assign inst_pc     = w_head.pc;
    assign fetch_error = r_error;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
`timescale 1ns/1ps
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_en, a_rv, a_ready, a_valid, a_err;
    logic [15:0] a_rpc, a_addr, a_rom, a_data, a_pc;
    logic        b_reset, b_en, b_rv, b_ready, b_valid, b_err;
    logic [15:0] b_rpc, b_addr, b_rom, b_data, b_pc;

    fetch_unit #(.RESET_PC(16'h0000), .MEMORY_SIZE(100), .BUF_DEPTH(2)) u_a (
        .clk(clk), .reset(a_reset), .fetch_enable(a_en), .rom_address(a_addr),
        .rom_instruction(a_rom), .redirect_valid(a_rv), .redirect_pc(a_rpc),
        .inst_valid(a_valid), .inst_ready(a_ready), .inst_data(a_data),
        .inst_pc(a_pc), .fetch_error(a_err)
    );

    fetch_unit #(.RESET_PC(16'h0000), .MEMORY_SIZE(8), .BUF_DEPTH(2)) u_b (
        .clk(clk), .reset(b_reset), .fetch_enable(b_en), .rom_address(b_addr),
        .rom_instruction(b_rom), .redirect_valid(b_rv), .redirect_pc(b_rpc),
        .inst_valid(b_valid), .inst_ready(b_ready), .inst_data(b_data),
        .inst_pc(b_pc), .fetch_error(b_err)
    );

    // ROM contents ROM[i] = A000 + i, one-cycle registered read
    always @(posedge clk) begin
        a_rom <= 16'hA000 + a_addr;
        b_rom <= 16'hA000 + b_addr;
    end

    int          n_chk = 0;
    int          n_bad = 0;
    logic [15:0] exp_a = 16'h0;
    logic [15:0] exp_b = 16'h0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] next_pc(input logic [15:0] pc, input int size);
        return (int'(pc) == size - 1) ? 16'h0 : pc + 16'd1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: delivered stream is consecutive PCs from reset/redirect target, data = ROM[pc]
    always @(negedge clk) begin
        if (a_reset) exp_a = 16'h0;
        else begin
            if (a_valid) begin
                check("a_head_pc", a_pc, exp_a);
                check("a_head_data", a_data, 16'hA000 + exp_a);
            end
            if (a_valid && a_ready) exp_a = next_pc(exp_a, 100);
            if (a_rv) exp_a = a_rpc;
        end
        if (b_reset) exp_b = 16'h0;
        else begin
            if (b_valid) begin
                check("b_head_pc", b_pc, exp_b);
                check("b_head_data", b_data, 16'hA000 + exp_b);
            end
            if (b_valid && b_ready) exp_b = next_pc(exp_b, 8);
            if (b_rv) exp_b = b_rpc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        logic        en_q, rv_q;
        a_reset = 1; a_en = 1; a_ready = 1; a_rv = 0; a_rpc = 0;
        b_reset = 1; b_en = 0; b_ready = 1; b_rv = 0; b_rpc = 0;
        repeat (3) cyc();

        check("rst_valid", 16'(a_valid), 16'd0);
        check("rst_addr", a_addr, 16'd0);
        check("rst_data", a_data, 16'd0);
        check("rst_pc", a_pc, 16'd0);
        check("rst_err", 16'(a_err), 16'd0);

        // Startup latency and gap-free streaming
        a_reset = 0;
        cyc();
        check("lat1_valid", 16'(a_valid), 16'd0);
        check("lat1_addr", a_addr, 16'd1);
        cyc();
        check("lat2_valid", 16'(a_valid), 16'd1);
        check("lat2_pc", a_pc, 16'd0);
        check("lat2_data", a_data, 16'hA000);
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("stream_nogap", 16'(a_valid), 16'd1);
        end

        // Backpressure: PC must freeze while decode stalls
        a_ready = 0;
        held = a_addr;
        repeat (4) cyc();
        check("stall_addr_hold", a_addr, held);
        check("stall_valid", 16'(a_valid), 16'd1);
        a_ready = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("resume_nogap", 16'(a_valid), 16'd1);
        end

        // Redirect while the skid buffer is committed
        a_ready = 0; a_rv = 1; a_rpc = 16'd40;
        cyc();
        a_rv = 0; a_ready = 1;
        check("redir_r1_valid", 16'(a_valid), 16'd0);
        cyc();
        check("redir_r2_valid", 16'(a_valid), 16'd0);
        cyc();
        check("redir_r3_valid", 16'(a_valid), 16'd1);
        check("redir_r3_pc", a_pc, 16'd40);
        check("redir_r3_data", a_data, 16'hA028);
        repeat (4) cyc();

        // Redirect together with a pop: the popped head still counts
        check("pop_redir_valid", 16'(a_valid), 16'd1);
        a_rv = 1; a_rpc = 16'd70;
        cyc();
        a_rv = 0;
        check("pop_redir_r1_valid", 16'(a_valid), 16'd0);
        repeat (2) cyc();
        check("pop_redir_r3_pc", a_pc, 16'd70);
        check("pop_redir_r3_data", a_data, 16'hA046);
        repeat (3) cyc();

        // Out-of-range redirect sets the error, reset clears it and overrides a redirect
        a_rv = 1; a_rpc = 16'd200;
        cyc();
        a_rv = 0;
        cyc();
        check("oob_err", 16'(a_err), 16'd1);
        cyc();
        check("oob_addr_hold", a_addr, 16'd200);
        check("oob_valid", 16'(a_valid), 16'd0);
        a_reset = 1; a_rv = 1; a_rpc = 16'd55;
        cyc();
        check("rst_mid_valid", 16'(a_valid), 16'd0);
        check("rst_mid_addr", a_addr, 16'd0);
        check("rst_mid_err", 16'(a_err), 16'd0);
        a_reset = 0; a_rv = 0;
        repeat (4) cyc();

        // Random ready, enable pattern 1,0,0,1, sparse random redirects
        for (int k = 0; k < 240; k++) begin
            a_en    = (k % 4 == 0) || (k % 4 == 3);
            a_ready = 1'($urandom_range(0, 1));
            a_rv    = ($urandom_range(0, 15) == 0);
            a_rpc   = 16'($urandom_range(0, 99));
            en_q = a_en; rv_q = a_rv;
            held = a_addr;
            cyc();
            if (!en_q && !rv_q) check("en0_no_issue", a_addr, held);
        end
        a_en = 0; a_rv = 0; a_ready = 1;
        repeat (6) cyc();
        check("drain_valid", 16'(a_valid), 16'd0);
        check("drain_all_delivered", a_addr, exp_a);

        // 8-word ROM: wrap, out-of-range redirect and recovery
        b_en = 1; b_reset = 0;
        repeat (6) cyc();
        check("wrap_addr6", b_addr, 16'd6);
        cyc();
        check("wrap_addr7", b_addr, 16'd7);
        cyc();
        check("wrap_addr0", b_addr, 16'd0);
        cyc();
        check("wrap_addr1", b_addr, 16'd1);
        repeat (4) cyc();
        b_rv = 1; b_rpc = 16'd9;
        cyc();
        b_rv = 0;
        check("b_oob_err_pre", 16'(b_err), 16'd0);
        cyc();
        check("b_oob_err", 16'(b_err), 16'd1);
        check("b_oob_addr", b_addr, 16'd9);
        repeat (2) cyc();
        check("b_oob_hold", b_addr, 16'd9);
        check("b_oob_drained", 16'(b_valid), 16'd0);
        b_rv = 1; b_rpc = 16'd3;
        cyc();
        b_rv = 0;
        check("b_recover_err", 16'(b_err), 16'd0);
        check("b_recover_addr", b_addr, 16'd3);
        repeat (2) cyc();
        check("b_recover_valid", 16'(b_valid), 16'd1);
        check("b_recover_pc", b_pc, 16'd3);
        check("b_recover_data", b_data, 16'hA003);
        repeat (10) cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
